// File: rtl/result_checker_pkg.sv
// Shared types, default sizes and helpers for the result checker.
package checker_pkg;

    // Run-control states of the checker engine.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Default geometry of the checked memories.
    localparam int DEF_DATA_W    = 21;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_NUM_WORDS = 1024;

    // Widest lane vector the popcount helper accepts, and the width of its result.
    localparam int MAX_LANES = 32;
    localparam int PC_W      = $clog2(MAX_LANES + 1);

    // Number of set bits in a lane-mismatch vector (zero-extend narrower vectors).
    function automatic logic [PC_W-1:0] popcount(input logic [MAX_LANES-1:0] vec);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + PC_W'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/result_checker_lane_compare.sv
// Masked compare of one result word against its expected word.
module lane_compare #(
    parameter int DATA_W = 21
) (
    input  logic [DATA_W-1:0] act_word,
    input  logic [DATA_W-1:0] exp_word,
    input  logic [DATA_W-1:0] mask,
    output logic              mismatch
);

    // Only bits selected by the mask can cause a mismatch.
    assign mismatch = |((act_word ^ exp_word) & mask);

endmodule

// File: rtl/result_checker.sv
// Start/done engine that sweeps a result memory and an expected memory in
// lock-step, compares LANES words per beat and reports error statistics.
module result_checker
    import checker_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int LANES     = 1,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       cmp_mask,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [LANES*DATA_W-1:0] act_data,
    input  logic [LANES*DATA_W-1:0] exp_data,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        err_count,
    output logic                    first_err_valid,
    output logic [ADDR_W-1:0]       first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - LANES);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(LANES);
    localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int                SUM_W     = CNT_W + PC_W;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [DATA_W-1:0]   mask_q;
    logic [RD_LAT-1:0]   pipe_valid;
    logic [ADDR_W-1:0]   pipe_addr [RD_LAT];
    logic                stat_pending;
    logic                beat_valid;
    logic [ADDR_W-1:0]   beat_addr;
    logic [LANES-1:0]    mismatch;
    logic [PC_W-1:0]     beat_pop;
    logic [SUM_W-1:0]    err_sum;
    logic [CNT_W-1:0]    err_next;
    logic [LANE_W-1:0]   first_lane;

    // A start is honoured only when no run is in progress.
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign beat_valid = pipe_valid[RD_LAT-1];
    assign beat_addr  = pipe_addr[RD_LAT-1];

    // One masked comparator per lane; lane 0 sits in the LSBs of the data buses.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_compare #(
            .DATA_W (DATA_W)
        ) u_lane (
            .act_word (act_data[k*DATA_W +: DATA_W]),
            .exp_word (exp_data[k*DATA_W +: DATA_W]),
            .mask     (mask_q),
            .mismatch (mismatch[k])
        );
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and run-status outputs decoded from the state.
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (rd_addr == LAST_ADDR) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave only after the last beat has also been folded into the statistics.
                if ((pipe_valid == '0) && !stat_pending) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
                if (start) state_next = ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read address: restarts at 0, steps by LANES while issuing, then holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (accept) begin
            rd_addr <= '0;
        end else if ((state == ISSUE) && (rd_addr != LAST_ADDR)) begin
            rd_addr <= rd_addr + STEP;
        end
    end

    // Valid tags of in-flight reads; cleared by reset so aborted beats are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Addresses travelling alongside the valid tags.
    // NOTE: this address array has no reset; its contents are ignored unless the matching valid tag is set.
    always_ff @(posedge clk) begin
        pipe_addr[0] <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    // Lowest failing lane of the current beat.
    always_comb begin
        first_lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (mismatch[k]) first_lane = LANE_W'(k);
        end
    end

    // Saturating accumulation of this beat's mismatch count.
    always_comb begin
        beat_pop = popcount(MAX_LANES'(mismatch));
        err_sum  = SUM_W'(err_count) + SUM_W'(beat_pop);
        err_next = (err_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end

    // Run statistics: cleared and mask latched on an accepted start, updated per tagged beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q          <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            stat_pending    <= 1'b0;
        end else begin
            stat_pending <= beat_valid;
            if (accept) begin
                mask_q          <= cmp_mask;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
            end else if (beat_valid) begin
                err_count <= err_next;
                if (!first_err_valid && (|mismatch)) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= beat_addr + ADDR_W'(first_lane);
                end
            end
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: three configurations driven from shared memories.
module tb_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [20:0] cmp_mask = 21'h1FFFFF;

    logic [20:0] act_mem [1024];
    logic [20:0] exp_mem [1024];

    int n_checks = 0;
    int n_fail   = 0;
    int viol_a   = 0;
    int viol_b   = 0;

    // Instance A: LANES=1, RD_LAT=1, 1024 words.
    logic        start_a = 1'b0;
    logic        rd_en_a, busy_a, done_a, pass_a, fev_a;
    logic [11:0] rd_addr_a, fea_a;
    logic [20:0] act_a, exp_a;
    logic [15:0] err_a;

    // Instance B: LANES=4, RD_LAT=3, 1024 words.
    logic        start_b = 1'b0;
    logic        rd_en_b, busy_b, done_b, pass_b, fev_b;
    logic [11:0] rd_addr_b, fea_b;
    logic [83:0] act_b1, act_b2, act_b, exp_b1, exp_b2, exp_b;
    logic [15:0] err_b;

    // Instance C: LANES=1, RD_LAT=2, 64 words, 4-bit counter.
    logic        start_c = 1'b0;
    logic        rd_en_c, busy_c, done_c, pass_c, fev_c;
    logic [11:0] rd_addr_c, fea_c;
    logic [20:0] act_c1, act_c, exp_c1, exp_c;
    logic [3:0]  err_c;

    always #5 clk = ~clk;

    result_checker #(.DATA_W(21), .ADDR_W(12), .NUM_WORDS(1024), .LANES(1), .RD_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .cmp_mask(cmp_mask), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .act_data(act_a), .exp_data(exp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_valid(fev_a), .first_err_addr(fea_a));

    result_checker #(.DATA_W(21), .ADDR_W(12), .NUM_WORDS(1024), .LANES(4), .RD_LAT(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .cmp_mask(cmp_mask), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .act_data(act_b), .exp_data(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_valid(fev_b), .first_err_addr(fea_b));

    result_checker #(.DATA_W(21), .ADDR_W(12), .NUM_WORDS(64), .LANES(1), .RD_LAT(2), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .cmp_mask(cmp_mask), .rd_en(rd_en_c), .rd_addr(rd_addr_c),
        .act_data(act_c), .exp_data(exp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_valid(fev_c), .first_err_addr(fea_c));

    function automatic logic [83:0] pack_act(input logic [11:0] a);
        logic [83:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*21 +: 21] = act_mem[(int'(a) + k) % 1024];
        return r;
    endfunction

    function automatic logic [83:0] pack_exp(input logic [11:0] a);
        logic [83:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*21 +: 21] = exp_mem[(int'(a) + k) % 1024];
        return r;
    endfunction

    // Memory models with the read latency each instance expects.
    always @(posedge clk) begin
        act_a  <= act_mem[rd_addr_a[9:0]];
        exp_a  <= exp_mem[rd_addr_a[9:0]];
        act_b1 <= pack_act(rd_addr_b);
        exp_b1 <= pack_exp(rd_addr_b);
        act_b2 <= act_b1;
        exp_b2 <= exp_b1;
        act_b  <= act_b2;
        exp_b  <= exp_b2;
        act_c1 <= act_mem[rd_addr_c[9:0]];
        exp_c1 <= exp_mem[rd_addr_c[9:0]];
        act_c  <= act_c1;
        exp_c  <= exp_c1;
    end

    // Out-of-range read address monitor.
    always @(posedge clk) begin
        if (rd_en_a && (rd_addr_a > 12'd1023)) viol_a <= viol_a + 1;
        if (rd_en_b && (rd_addr_b > 12'd1020)) viol_b <= viol_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic restore_mem();
        for (int i = 0; i < 1024; i++) act_mem[i] = exp_mem[i];
    endtask

    // Pulse start, count cycles from the start edge until done, optionally re-pulse start mid-run.
    task automatic run(input int which, input int poke_at, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        while (!seen && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            set_start(which, cycles == poke_at);
            seen = done_of(which);
        end
        set_start(which, 1'b0);
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int   cyc;
        logic hit;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 21'((i * 7919 + 12345) & 32'h1FFFFF);
        restore_mem();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_rd_en",   {31'd0, rd_en_a}, 32'd0);
        check("rst_busy",    {31'd0, busy_a},  32'd0);
        check("rst_done",    {31'd0, done_a},  32'd0);
        check("rst_pass",    {31'd0, pass_a},  32'd0);
        check("rst_fev",     {31'd0, fev_a},   32'd0);
        check("rst_err",     {16'd0, err_a},   32'd0);
        check("rst_fea",     {20'd0, fea_a},   32'd0);
        check("rst_rd_addr", {20'd0, rd_addr_a}, 32'd0);

        // Identical memories.
        run(0, -1, cyc);
        check("same_latency", cyc, 32'd1027);
        check("same_pass",    {31'd0, pass_a}, 32'd1);
        check("same_err",     {16'd0, err_a},  32'd0);
        check("same_fev",     {31'd0, fev_a},  32'd0);
        check("same_busy",    {31'd0, busy_a}, 32'd0);
        check("same_addr_hold", {20'd0, rd_addr_a}, 32'd1023);

        // Three corrupted words.
        act_mem[5]    = exp_mem[5]    ^ 21'h80;
        act_mem[300]  = exp_mem[300]  ^ 21'h80;
        act_mem[1023] = exp_mem[1023] ^ 21'h80;
        run(0, -1, cyc);
        check("c3_err",  {16'd0, err_a},  32'd3);
        check("c3_fea",  {20'd0, fea_a},  32'd5);
        check("c3_fev",  {31'd0, fev_a},  32'd1);
        check("c3_pass", {31'd0, pass_a}, 32'd0);
        check("c3_addr_viol", viol_a, 32'd0);

        // Start pulsed mid-run is ignored.
        run(0, 100, cyc);
        check("poke_latency", cyc, 32'd1027);
        check("poke_err", {16'd0, err_a}, 32'd3);

        // Reset at word 512, then a fresh run.
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = (rd_addr_a == 12'd512);
        end
        check("reach_512", {31'd0, hit}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_rd_en", {31'd0, rd_en_a}, 32'd0);
        check("abort_busy",  {31'd0, busy_a},  32'd0);
        check("abort_err",   {16'd0, err_a},   32'd0);
        check("abort_fev",   {31'd0, fev_a},   32'd0);
        check("abort_addr",  {20'd0, rd_addr_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", {31'd0, done_a}, 32'd0);
        run(0, -1, cyc);
        check("fresh_latency", cyc, 32'd1027);
        check("fresh_err", {16'd0, err_a}, 32'd3);

        // Four lanes, RD_LAT=3, words 8 and 10 in one beat.
        restore_mem();
        act_mem[8]  = exp_mem[8]  ^ 21'h10000;
        act_mem[10] = exp_mem[10] ^ 21'h00001;
        run(1, -1, cyc);
        check("l4_latency", cyc, 32'd261);
        check("l4_err",  {16'd0, err_b},  32'd2);
        check("l4_fea",  {20'd0, fea_b},  32'd8);
        check("l4_pass", {31'd0, pass_b}, 32'd0);
        check("l4_addr_hold", {20'd0, rd_addr_b}, 32'd1020);
        check("l4_addr_viol", viol_b, 32'd0);

        // LSB-only differences in 100 words under three masks.
        restore_mem();
        for (int i = 0; i < 100; i++) act_mem[10*i+3] = exp_mem[10*i+3] ^ 21'h1;
        cmp_mask = 21'h1FFFFE;
        run(0, -1, cyc);
        check("lsb_masked_pass", {31'd0, pass_a}, 32'd1);
        check("lsb_masked_err",  {16'd0, err_a},  32'd0);
        cmp_mask = 21'h1FFFFF;
        run(0, -1, cyc);
        check("lsb_full_err",  {16'd0, err_a},  32'd100);
        check("lsb_full_fea",  {20'd0, fea_a},  32'd3);
        check("lsb_full_pass", {31'd0, pass_a}, 32'd0);
        cmp_mask = 21'h0;
        run(0, -1, cyc);
        check("mask0_pass", {31'd0, pass_a}, 32'd1);
        check("mask0_err",  {16'd0, err_a},  32'd0);
        cmp_mask = 21'h1FFFFF;

        // 4-bit counter saturates with 40 mismatches.
        restore_mem();
        for (int i = 0; i < 40; i++) act_mem[i] = exp_mem[i] ^ 21'h8;
        run(2, -1, cyc);
        check("sat_latency", cyc, 32'd68);
        check("sat_err",  {28'd0, err_c},  32'd15);
        check("sat_fea",  {20'd0, fea_c},  32'd0);
        check("sat_pass", {31'd0, pass_c}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Synthesizable self-checking block. It sweeps a result memory (e.g. the matrix-multiply output memory) and an expected-value memory in lock-step, compares words, and reports the error count, the first failing address and pass/fail.
- It replaces the software compare loop with a start/done engine that any top controller or FPGA bring-up wrapper can trigger.
- It is generalised in word width, depth, lanes compared per cycle, memory read latency and compare mask.

Parameters:
- DATA_W, 21, bits per word
- ADDR_W, 12, memory address width
- NUM_WORDS, 1024, words to check; must be a multiple of LANES and ≤ 2^ADDR_W
- LANES, 1, words compared per cycle; the memory port is LANES words wide
- RD_LAT, 1, cycles from rd_en to valid read data (1..4)
- CNT_W, 16, width of the error counter

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start request; honoured only in IDLE or DONE
- cmp_mask  in  DATA_W  bit=1 means the bit is compared; sampled at start and held for the whole run
- rd_en  out  1  read strobe to both memories
- rd_addr  out  ADDR_W  word address of lane 0; lane k reads rd_addr+k
- act_data  in  LANES*DATA_W  result-memory data, lane 0 in the LSBs
- exp_data  in  LANES*DATA_W  expected-memory data, same packing
- busy  out  1  high from the cycle after an accepted start until done rises
- done  out  1  level; high once the run completes, cleared by the next accepted start
- pass  out  1  valid while done is high; 1 iff err_count==0
- err_count  out  CNT_W  mismatching words; saturates at all-ones
- first_err_valid  out  1  a mismatch has been captured in this run
- first_err_addr  out  ADDR_W  address of the first mismatching word (lowest lane wins within a beat)

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. rd_en, busy, done, pass, first_err_valid = 0; err_count, first_err_addr, rd_addr = 0.
- FSM states:
  - IDLE: start → ISSUE. On the same edge: clear counters and flags, latch cmp_mask, clear done.
  - ISSUE: rd_en=1 and rd_addr advances by LANES each cycle from 0. After the beat with rd_addr = NUM_WORDS-LANES → DRAIN.
  - DRAIN: rd_en=0. Wait until every in-flight beat has been compared (pipeline valid vector empty) → DONE.
  - DONE: done=1, pass=(err_count==0). start → ISSUE with the same clearing as in IDLE.
- Read pipeline: a RD_LAT-deep shift register carries {valid, addr}. Data presented with a valid tag is compared in that cycle. Statistics are registered, so they update one cycle after the data arrives.
- Compare per lane: mismatch_k = |((act_k ^ exp_k) & mask). A beat adds popcount(mismatch) to err_count, saturating at 2^CNT_W-1 with no wrap.
- First error: on the first beat with any mismatch while first_err_valid=0, capture addr + lowest failing k and set first_err_valid. Later mismatches never overwrite it.
- Total latency, start to done: 1 + NUM_WORDS/LANES + RD_LAT + 1 cycles.
- start while busy: ignored, and the run is not restarted.
- cmp_mask=0: every compare passes, so pass=1.
- Reset mid-run: aborts immediately to reset values. In-flight pipeline data is discarded and done does not rise.
- rd_addr must never exceed NUM_WORDS-LANES. It holds its last value in DRAIN and DONE.

Decomposition:
- Package checker_pkg holds:
  - the state enum {IDLE, ISSUE, DRAIN, DONE}
  - default constants (DATA_W=21, ADDR_W=12, NUM_WORDS=1024)
  - a popcount function for LANES-bit vectors
- Sub-module lane_compare: one DATA_W-bit masked compare producing the mismatch bit, instantiated LANES times via generate.

Test Plan:
- Identical memories, 1024 words, LANES=1, RD_LAT=1: done exactly 1027 cycles after the start edge; pass=1, err_count=0, first_err_valid=0.
- Corrupt words 5, 300 and 1023 in the result memory: err_count=3, first_err_addr=5, pass=0; rd_addr never exceeds 1023.
- LANES=4, RD_LAT=3, words 8 and 10 corrupted (same beat): err_count=2, first_err_addr=8; done after 1+256+3+1 cycles.
- cmp_mask=21'h1FFFFE with only LSB differences in 100 words: pass=1. Rerun with mask 21'h1FFFFF: err_count=100.
- CNT_W=4 with 40 mismatches: err_count saturates at 15.
- start pulsed mid-run: ignored. rst asserted at word 512: all outputs reset asynchronously. A fresh start then completes normally with err_count equal to the full-run count.
